// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: store-buffer entry
// layout, byte-mask constants and byte-lane helpers.
package dmem_pkg;

    localparam int SB_IDX_W = 30;

    localparam logic [3:0] MASK_WORD = 4'hF;
    localparam logic [3:0] MASK_B0   = 4'h1;
    localparam logic [3:0] MASK_B1   = 4'h2;
    localparam logic [3:0] MASK_B2   = 4'h4;
    localparam logic [3:0] MASK_B3   = 4'h8;

    typedef struct packed {
        logic [SB_IDX_W-1:0] idx;
        logic [31:0]         data;
        logic [3:0]          mask;
    } sb_entry_t;

    function automatic logic [31:0] replicate_lane(input logic [7:0] lane_val);
        return {4{lane_val}};
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        logic [3:0] m;
        case (lane)
            2'd0:    m = MASK_B0;
            2'd1:    m = MASK_B1;
            2'd2:    m = MASK_B2;
            2'd3:    m = MASK_B3;
            default: m = MASK_B0;
        endcase
        return m;
    endfunction

    // Bytes selected by mask come from data, the rest keep base.
    function automatic logic [31:0] merge_masked(input logic [31:0] base,
                                                 input logic [31:0] data,
                                                 input logic [3:0]  mask);
        logic [31:0] m32;
        m32 = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        return (base & ~m32) | (data & m32);
    endfunction

endpackage

// File: rtl/dmem_responder_store_buffer_fifo.sv
// Circular store buffer: entry registers, head/tail/count and a per-entry
// valid vector used by the load-forwarding merge.
module store_buffer_fifo
    import dmem_pkg::*;
#(
    parameter  int SB_DEPTH = 2,
    localparam int PTR_W    = $clog2(SB_DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  sb_entry_t                  push_entry,
    output sb_entry_t [SB_DEPTH-1:0]   entries,
    output logic [SB_DEPTH-1:0]        valid,
    output logic [PTR_W-1:0]           head,
    output logic [CNT_W-1:0]           count,
    output logic                       empty
);

    logic [PTR_W-1:0]          head_r;
    logic [PTR_W-1:0]          tail_r;
    logic [CNT_W-1:0]          count_r;
    sb_entry_t [SB_DEPTH-1:0]  entry_r;
    logic [SB_DEPTH-1:0]       valid_s;

    // Pointer and occupancy update; pointers wrap naturally at SB_DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                tail_r <= tail_r + PTR_W'(1'b1);
            end
            if (pop) begin
                head_r <= head_r + PTR_W'(1'b1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage written at the tail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_r <= '0;
        end else if (push) begin
            entry_r[tail_r] <= push_entry;
        end
    end

    // An entry is live when its distance from head is below the occupancy
    always_comb begin
        logic [PTR_W-1:0] offset;
        valid_s = {SB_DEPTH{1'b0}};
        for (int i = 0; i < SB_DEPTH; i++) begin
            offset     = PTR_W'(i) - head_r;
            valid_s[i] = ({1'b0, offset} < count_r);
        end
    end

    assign entries = entry_r;
    assign valid   = valid_s;
    assign head    = head_r;
    assign count   = count_r;
    assign empty   = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single-port word RAM behind a store buffer, with
// loads taking priority and forwarding from buffered stores.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int SB_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic                      MemByte,
    input  logic [31:0]               Addr,
    input  logic [31:0]               WriteData,
    output logic [31:0]               ReadData,
    output logic                      StallMem,
    output logic                      SbEmpty,
    output logic [$clog2(SB_DEPTH):0] SbCount
);

    localparam int PTR_W     = $clog2(SB_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int RAM_DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] SB_FULL = CNT_W'(SB_DEPTH);

    logic [ADDR_W-1:0]         word_idx_s;
    logic [1:0]                lane_s;
    logic                      addr_unused_s;
    logic                      load_s;
    logic                      drain_s;
    logic                      accept_s;
    sb_entry_t                 new_entry_s;
    sb_entry_t [SB_DEPTH-1:0]  entries_s;
    sb_entry_t                 head_entry_s;
    logic [SB_DEPTH-1:0]       valid_s;
    logic [PTR_W-1:0]          head_s;
    logic [CNT_W-1:0]          count_s;
    logic                      empty_s;
    logic [31:0]               merged_s;
    logic [7:0]                lane_byte_s;
    logic [31:0]               mem_r [0:RAM_DEPTH-1];

    assign word_idx_s    = Addr[ADDR_W+1:2];
    assign lane_s        = Addr[1:0];
    // Upper address bits alias onto the RAM
    assign addr_unused_s = ^Addr[31:ADDR_W+2];

    assign load_s   = MemRead & ~MemWrite;
    assign drain_s  = ~empty_s & ~load_s;
    assign accept_s = MemWrite & ((count_s < SB_FULL) | drain_s);
    assign StallMem = MemWrite & ~accept_s;

    // Build the buffer entry for the incoming store
    always_comb begin
        new_entry_s     = '0;
        new_entry_s.idx = SB_IDX_W'(word_idx_s);
        if (MemByte) begin
            new_entry_s.data = replicate_lane(WriteData[7:0]);
            new_entry_s.mask = lane_mask(lane_s);
        end else begin
            new_entry_s.data = WriteData;
            new_entry_s.mask = MASK_WORD;
        end
    end

    store_buffer_fifo #(
        .SB_DEPTH (SB_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push       (accept_s),
        .pop        (drain_s),
        .push_entry (new_entry_s),
        .entries    (entries_s),
        .valid      (valid_s),
        .head       (head_s),
        .count      (count_s),
        .empty      (empty_s)
    );

    assign head_entry_s = entries_s[head_s];

    // Commit the head entry into RAM under its byte mask; RAM is never reset
    always_ff @(posedge clk) begin
        if (drain_s) begin
            mem_r[head_entry_s.idx[ADDR_W-1:0]] <=
                merge_masked(mem_r[head_entry_s.idx[ADDR_W-1:0]],
                             head_entry_s.data, head_entry_s.mask);
        end
    end

    // Overlay matching buffered stores oldest first so the youngest byte wins
    always_comb begin
        logic [PTR_W-1:0] pos;
        merged_s = mem_r[word_idx_s];
        pos      = head_s;
        for (int k = 0; k < SB_DEPTH; k++) begin
            pos = head_s + PTR_W'(k);
            if (valid_s[pos] && (entries_s[pos].idx == SB_IDX_W'(word_idx_s))) begin
                merged_s = merge_masked(merged_s, entries_s[pos].data, entries_s[pos].mask);
            end else begin
                merged_s = merged_s;
            end
        end
    end

    // Select the addressed byte lane of the merged word
    always_comb begin
        case (lane_s)
            2'd0:    lane_byte_s = merged_s[7:0];
            2'd1:    lane_byte_s = merged_s[15:8];
            2'd2:    lane_byte_s = merged_s[23:16];
            2'd3:    lane_byte_s = merged_s[31:24];
            default: lane_byte_s = merged_s[7:0];
        endcase
    end

    // Load data mux
    always_comb begin
        if (!load_s) begin
            ReadData = 32'h0000_0000;
        end else if (MemByte) begin
            ReadData = {24'h00_0000, lane_byte_s};
        end else begin
            ReadData = merged_s;
        end
    end

    assign SbEmpty = empty_s;
    assign SbCount = count_s;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder with hand-written
// sequences for full-buffer, reset, ordering and wrap corners.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic        mem_byte;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] read_data;
    logic        stall_mem;
    logic        sb_empty;
    logic [1:0]  sb_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        by;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_d;
        logic [1:0]  exp_c;
        logic        exp_s;
    } vec_t;

    vec_t vecs[14];

    dmem_responder #(
        .ADDR_W   (8),
        .SB_DEPTH (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (mem_read),
        .MemWrite  (mem_write),
        .MemByte   (mem_byte),
        .Addr      (addr),
        .WriteData (wdata),
        .ReadData  (read_data),
        .StallMem  (stall_mem),
        .SbEmpty   (sb_empty),
        .SbCount   (sb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic by,
                         input logic [31:0] a, input logic [31:0] d);
        mem_read  = rd;
        mem_write = wr;
        mem_byte  = by;
        addr      = a;
        wdata     = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, then clock.
    task automatic run(input logic rd, input logic wr, input logic by,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_d, input logic [1:0] exp_c,
                       input logic exp_s, input string tag);
        drive(rd, wr, by, a, d);
        #1;
        chk({tag, " data"},  read_data, exp_d);
        chk({tag, " count"}, {30'd0, sb_count}, {30'd0, exp_c});
        chk({tag, " stall"}, {31'd0, stall_mem}, {31'd0, exp_s});
        chk({tag, " empty"}, {31'd0, sb_empty}, {31'd0, (exp_c == 2'd0)});
        step();
    endtask

    initial begin
        //           rd    wr    by    addr          wdata          exp data       cnt   stall
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 2'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 2'd1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'd1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000, 2'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'd1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0022, 32'h1234_56AA, 32'h0000_0000, 2'd0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h11AA_3344, 2'd1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0022, 32'h0000_0000, 32'h0000_00AA, 2'd1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0023, 32'h0000_0000, 32'h0000_0011, 2'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'd1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0000_0023, 32'h0000_0000, 32'h11AA_3344, 2'd0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 2'd0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 32'h0000_0044, 2'd0, 1'b0};

        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("reset count", {30'd0, sb_count}, 32'd0);
        chk("reset empty", {31'd0, sb_empty}, 32'd1);
        chk("reset stall", {31'd0, stall_mem}, 32'd0);
        chk("reset data",  read_data, 32'h0);
        step();
        step();
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run(vecs[i].rd, vecs[i].wr, vecs[i].by, vecs[i].a, vecs[i].d,
                vecs[i].exp_d, vecs[i].exp_c, vecs[i].exp_s, $sformatf("vec%0d", i));
        end

        // Fill with drains held off, then stall on a third store
        force dut.drain_s = 1'b0;
        run(1'b0, 1'b1, 1'b0, 32'h30, 32'hA0A0_A0A0, 32'h0, 2'd0, 1'b0, "fill0");
        run(1'b0, 1'b1, 1'b0, 32'h34, 32'hB1B1_B1B1, 32'h0, 2'd1, 1'b0, "fill1");
        run(1'b0, 1'b1, 1'b0, 32'h38, 32'hC2C2_C2C2, 32'h0, 2'd2, 1'b1, "stall");
        release dut.drain_s;
        run(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 32'hA0A0_A0A0, 2'd2, 1'b0, "hold0");
        run(1'b1, 1'b0, 1'b0, 32'h34, 32'h0, 32'hB1B1_B1B1, 2'd2, 1'b0, "hold1");
        run(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 32'hA0A0_A0A0, 2'd2, 1'b0, "hold2");
        run(1'b0, 1'b1, 1'b0, 32'h38, 32'hC2C2_C2C2, 32'h0, 2'd2, 1'b0, "full_acc");
        run(1'b1, 1'b1, 1'b0, 32'h3C, 32'hD3D3_D3D3, 32'h0, 2'd2, 1'b0, "rd_wr");
        run(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, "drain2");
        run(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0, "drain1");
        run(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 32'hA0A0_A0A0, 2'd0, 1'b0, "ram30");
        run(1'b1, 1'b0, 1'b0, 32'h34, 32'h0, 32'hB1B1_B1B1, 2'd0, 1'b0, "ram34");
        run(1'b1, 1'b0, 1'b0, 32'h38, 32'h0, 32'hC2C2_C2C2, 2'd0, 1'b0, "ram38");
        run(1'b1, 1'b0, 1'b0, 32'h3C, 32'h0, 32'hD3D3_D3D3, 2'd0, 1'b0, "ram3c");

        // Same-word stores: youngest byte wins, drain keeps order
        force dut.drain_s = 1'b0;
        run(1'b0, 1'b1, 1'b0, 32'h50, 32'h7777_7777, 32'h0, 2'd0, 1'b0, "ord_w");
        run(1'b0, 1'b1, 1'b1, 32'h51, 32'h0000_0099, 32'h0, 2'd1, 1'b0, "ord_b");
        release dut.drain_s;
        run(1'b1, 1'b0, 1'b0, 32'h50, 32'h0, 32'h7777_9977, 2'd2, 1'b0, "ord_fwd");
        run(1'b1, 1'b0, 1'b1, 32'h51, 32'h0, 32'h0000_0099, 2'd2, 1'b0, "ord_fwdb");
        run(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, "ord_dr2");
        run(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0, "ord_dr1");
        run(1'b1, 1'b0, 1'b0, 32'h50, 32'h0, 32'h7777_9977, 2'd0, 1'b0, "ord_ram");

        // Reset mid-operation discards buffered stores
        force dut.drain_s = 1'b0;
        run(1'b0, 1'b1, 1'b0, 32'h10, 32'h5555_5555, 32'h0, 2'd0, 1'b0, "rst_f0");
        run(1'b0, 1'b1, 1'b0, 32'h20, 32'h6666_6666, 32'h0, 2'd1, 1'b0, "rst_f1");
        release dut.drain_s;
        run(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h5555_5555, 2'd2, 1'b0, "rst_pre");
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_async count", {30'd0, sb_count}, 32'd0);
        chk("rst_async empty", {31'd0, sb_empty}, 32'd1);
        step();
        step();
        reset = 1'b1;
        run(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 2'd0, 1'b0, "rst_old10");
        run(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h11AA_3344, 2'd0, 1'b0, "rst_old20");

        // Address aliasing above the RAM index bits
        run(1'b0, 1'b1, 1'b0, 32'h400, 32'h1357_9BDF, 32'h0, 2'd0, 1'b0, "alias_st");
        run(1'b1, 1'b0, 1'b0, 32'h000, 32'h0, 32'h1357_9BDF, 2'd1, 1'b0, "alias_fwd");
        run(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0, "alias_dr");
        run(1'b1, 1'b0, 1'b0, 32'h000, 32'h0, 32'h1357_9BDF, 2'd0, 1'b0, "alias_ram");

        // Back-to-back stores with concurrent drains wrap the pointers
        for (int i = 0; i < 10; i++) begin
            run(1'b0, 1'b1, 1'b0, 32'h80 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 32'h0,
                (i == 0) ? 2'd0 : 2'd1, 1'b0, $sformatf("wrap_st%0d", i));
        end
        run(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0, "wrap_dr");
        for (int i = 0; i < 10; i++) begin
            run(1'b1, 1'b0, 1'b0, 32'h80 + 32'(4 * i), 32'h0, 32'hC0DE_0000 + 32'(i),
                2'd0, 1'b0, $sformatf("wrap_ld%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
